// File: rtl/fifo_pkt_pkg.sv
// rtl/fifo_pkt_pkg.sv - shared constants and word layout for the packed write FIFO
//
// Purpose: lane geometry, sequence width, field offsets and the packed word
// type shared by the write-side packer and the FIFO reader.
// Word layout (140 bits): [139:133] seq, [132] last, [131:128] lane mask,
// [127:0] lanes, with lane k at [32k+31:32k].
package fifo_pkt_pkg;

  localparam int LANE_W   = 32;
  localparam int LANES    = 4;
  localparam int SEQ_W    = 7;
  localparam int DATA_W   = LANES * LANE_W;
  localparam int WORD_W   = DATA_W + LANES + 1 + SEQ_W;
  localparam int CNT_W    = $clog2(LANES);

  localparam int SEQ_LSB  = 133;
  localparam int LAST_BIT = 132;
  localparam int MASK_LSB = 128;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic              last;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/fifo_wr_packer.sv
// rtl/fifo_wr_packer.sv - packs 32-bit beats into 140-bit FIFO words on the write side
//
// Purpose: accumulates up to LANES input beats into one FIFO word with a lane
// mask, last flag and sequence number, and drives the async FIFO write port.
// A partial word is pushed out by the flush input or by the idle timer.
// Ports:
//   wrclk, wrrst_n        write-domain clock, async active-low reset
//   s_valid/s_ready       input beat handshake; s_data payload, s_last end of packet
//   flush                 level request to push out a partial word (last=0)
//   fifo_wren/wrdata      FIFO write port; fifo_wrfull blocks writes
//   pkt_cnt               count of words written with last=1 (wraps)
module fifo_wr_packer
  import fifo_pkt_pkg::*;
#(
  parameter int IDLE_TO = 16
) (
  input  logic              wrclk,
  input  logic              wrrst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LANE_W-1:0] s_data,
  input  logic              s_last,
  input  logic              flush,
  output logic              fifo_wren,
  output logic [WORD_W-1:0] fifo_wrdata,
  input  logic              fifo_wrfull,
  output logic [15:0]       pkt_cnt
);

  localparam int TMR_W = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);

  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [SEQ_W-1:0]  seq;
  logic [TMR_W-1:0]  timer;
  logic              out_vld;
  logic              out_last;
  logic [LANES-1:0]  out_mask;
  logic [DATA_W-1:0] out_data;

  logic              drain;
  logic              accept;
  logic              complete;
  logic              timeout;
  logic              flush_go;
  logic [DATA_W-1:0] merged;
  logic [LANES-1:0]  full_mask;
  logic [LANES-1:0]  part_mask;
  fifo_word_t        word;

  always_comb begin
    drain    = out_vld && !fifo_wrfull;
    s_ready  = !out_vld || !fifo_wrfull;
    accept   = s_valid && s_ready;
    complete = accept && ((cnt == CNT_W'(LANES - 1)) || s_last);
    // Timer saturates at TMR_MAX, so a timeout blocked by a full output stays pending.
    timeout  = (IDLE_TO != 0) && (cnt != '0) && (timer == TMR_MAX);
    // s_ready doubles as "output register free this cycle".
    flush_go = (flush || timeout) && (cnt != '0) && !accept && s_ready;

    merged = acc;
    merged[int'(cnt)*LANE_W +: LANE_W] = s_data;
    for (int k = 0; k < LANES; k++) begin
      full_mask[k] = (k <= int'(cnt));
      part_mask[k] = (k < int'(cnt));
    end

    // seq is stamped at write time, so the word always carries the order it enters the FIFO.
    word.seq  = seq;
    word.last = out_last;
    word.mask = out_mask;
    word.data = out_data;
  end

  assign fifo_wren   = drain;
  assign fifo_wrdata = word;

  always_ff @(posedge wrclk or negedge wrrst_n) begin
    if (!wrrst_n) begin
      acc      <= '0;
      cnt      <= '0;
      seq      <= '0;
      timer    <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_mask <= '0;
      out_data <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (drain) begin
        seq <= seq + 1'b1;
        if (out_last) pkt_cnt <= pkt_cnt + 16'd1;
      end

      if (complete) begin
        out_vld  <= 1'b1;
        out_last <= s_last;
        out_mask <= full_mask;
        out_data <= merged;
        cnt      <= '0;
        acc      <= '0;
      end else if (flush_go) begin
        out_vld  <= 1'b1;
        out_last <= 1'b0;
        out_mask <= part_mask;
        out_data <= acc;
        cnt      <= '0;
        acc      <= '0;
      end else begin
        if (drain) out_vld <= 1'b0;
        if (accept) begin
          acc <= merged;
          cnt <= cnt + 1'b1;
        end
      end

      if (accept || flush_go || (cnt == '0)) begin
        timer <= '0;
      end else if (timer != TMR_MAX) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb/tb_fifo_wr_packer.sv - scoreboard testbench for fifo_wr_packer
module tb_fifo_wr_packer;
  import fifo_pkt_pkg::*;

  logic              wrclk = 1'b0;
  logic              wrrst_n;
  logic              s_valid;
  logic              s_ready;
  logic [LANE_W-1:0] s_data;
  logic              s_last;
  logic              flush;
  logic              fifo_wren;
  logic [WORD_W-1:0] fifo_wrdata;
  logic              fifo_wrfull;
  logic [15:0]       pkt_cnt;

  always #5 wrclk = ~wrclk;

  fifo_wr_packer #(.IDLE_TO(16)) dut (
    .wrclk       (wrclk),
    .wrrst_n     (wrrst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .flush       (flush),
    .fifo_wren   (fifo_wren),
    .fifo_wrdata (fifo_wrdata),
    .fifo_wrfull (fifo_wrfull),
    .pkt_cnt     (pkt_cnt)
  );

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] mon_exp;
  logic [SEQ_W-1:0]  exp_seq;
  logic [15:0]       exp_pkt;
  int n_cmp = 0;
  int n_err = 0;
  int full_viol = 0;
  bit toggle_stop;

  task automatic check_word(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected word for the next FIFO write; seq follows the order of pushes.
  task automatic push(input logic last, input logic [3:0] mask,
                      input logic [31:0] d3, input logic [31:0] d2,
                      input logic [31:0] d1, input logic [31:0] d0);
    exp_q.push_back({exp_seq, last, mask, d3, d2, d1, d0});
    exp_seq = exp_seq + 1'b1;
    if (last) exp_pkt = exp_pkt + 16'd1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int k;
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    rdy     = 1'b0;
    for (k = 0; k < 500; k++) begin
      @(negedge wrclk);
      rdy = s_ready;
      @(posedge wrclk);
      #1;
      if (rdy) break;
    end
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: beat %h never accepted", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge wrclk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size());
    end
    @(posedge wrclk);
    #1;
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge wrclk) begin
    if (wrrst_n) begin
      if (fifo_wren && fifo_wrfull) full_viol++;
      if (fifo_wren) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %h expected no write", fifo_wrdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check_word("write_word", fifo_wrdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    wrrst_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    flush   = 1'b0;
    fifo_wrfull = 1'b0;
    exp_seq = '0;
    exp_pkt = '0;
    toggle_stop = 1'b0;
    repeat (3) @(posedge wrclk);
    #1;
    check_int("rst_wren", int'(fifo_wren), 0);
    check_word("rst_wrdata", fifo_wrdata, '0);
    check_int("rst_pkt_cnt", int'(pkt_cnt), 0);
    check_int("rst_s_ready", int'(s_ready), 1);
    wrrst_n = 1'b1;
    @(posedge wrclk);
    #1;

    // 1: four beats, last on the fourth -> full word, one-cycle write latency
    push(1'b1, 4'hF, 32'h44, 32'h33, 32'h22, 32'h11);
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    send(32'h44, 1'b1);
    check_int("t1_wren_latency", int'(fifo_wren), 1);
    wait_empty("t1");
    check_int("t1_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    // 2: short packet, upper lanes zero
    push(1'b1, 4'h3, 32'h0, 32'h0, 32'hB, 32'hA);
    send(32'hA, 1'b0);
    send(32'hB, 1'b1);
    wait_empty("t2");
    check_int("t2_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    // 3: single beat then idle -> timer flush on idle cycle 16
    push(1'b0, 4'h1, 32'h0, 32'h0, 32'h0, 32'hC);
    send(32'hC, 1'b0);
    for (k = 1; k <= 40; k++) begin
      @(posedge wrclk);
      #1;
      if (fifo_wren) break;
    end
    check_int("t3_idle_cycles", k, 16);
    wait_empty("t3");
    check_int("t3_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    // 3b: explicit flush of a two-lane partial word
    push(1'b0, 4'h3, 32'h0, 32'h0, 32'hE, 32'hD);
    send(32'hD, 1'b0);
    send(32'hE, 1'b0);
    flush = 1'b1;
    @(posedge wrclk);
    #1;
    flush = 1'b0;
    wait_empty("t3b");

    // 4: hold full with a pending word while input keeps streaming
    fifo_wrfull = 1'b1;
    push(1'b1, 4'hF, 32'h103, 32'h102, 32'h101, 32'h100);
    push(1'b1, 4'hF, 32'h203, 32'h202, 32'h201, 32'h200);
    push(1'b1, 4'h3, 32'h0, 32'h0, 32'h301, 32'h300);
    for (k = 0; k < 4; k++) send(32'h100 + 32'(k), k == 3);
    bad = 0;
    fork
      begin
        for (int j = 0; j < 4; j++) send(32'h200 + 32'(j), j == 3);
        send(32'h300, 1'b0);
        send(32'h301, 1'b1);
      end
      begin
        repeat (20) begin
          @(negedge wrclk);
          if (fifo_wren || s_ready) bad++;
        end
        @(posedge wrclk);
        #1;
        fifo_wrfull = 1'b0;
      end
    join
    check_int("t4_full_stall_cycles", bad, 0);
    wait_empty("t4");
    check_int("t4_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    // 5: 130 full words with random back-pressure; seq wraps 127 -> 0
    fork
      begin
        for (int i = 0; i < 130; i++) begin
          push(1'b1, 4'hF, 32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4));
          for (int j = 0; j < 4; j++) send(32'(i*4+j), j == 3);
        end
        toggle_stop = 1'b1;
      end
      begin
        while (!toggle_stop) begin
          @(posedge wrclk);
          #1;
          fifo_wrfull = ($urandom_range(0, 3) == 0);
        end
        fifo_wrfull = 1'b0;
      end
    join
    wait_empty("t5");
    check_int("t5_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    // 6a: reset while a pending word is being presented
    fifo_wrfull = 1'b1;
    for (k = 0; k < 4; k++) send(32'h500 + 32'(k), k == 3);
    @(posedge wrclk);
    #1;
    fifo_wrfull = 1'b0;
    #1;
    check_int("t6_wren_before_rst", int'(fifo_wren), 1);
    wrrst_n = 1'b0;
    #1;
    check_int("t6_wren_in_rst", int'(fifo_wren), 0);
    check_word("t6_wrdata_in_rst", fifo_wrdata, '0);
    @(posedge wrclk);
    #1;
    wrrst_n = 1'b1;
    exp_seq = '0;
    exp_pkt = '0;
    check_int("t6_queue_empty", exp_q.size(), 0);

    // 6b: reset with two lanes accumulated; no stale lanes afterwards
    send(32'h600, 1'b0);
    send(32'h601, 1'b0);
    wrrst_n = 1'b0;
    @(posedge wrclk);
    #1;
    wrrst_n = 1'b1;
    check_int("t6_pkt_cnt_rst", int'(pkt_cnt), int'(exp_pkt));
    push(1'b1, 4'h1, 32'h0, 32'h0, 32'h0, 32'h700);
    send(32'h700, 1'b1);
    wait_empty("t6");
    check_int("t6_pkt_cnt", int'(pkt_cnt), int'(exp_pkt));

    check_int("wren_while_full", full_viol, 0);
    check_int("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
